// File: rtl/alu_sequencer.sv
// Fetch/decode sequencer feeding the 8-register ALU: reads 16-bit words from a synchronous
// program ROM and issues one ALU control bundle per instruction, plus din for two-word LDI.
module alu_sequencer #(
    parameter int unsigned AW    = 8,
    parameter int unsigned START = 0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          run,
    input  logic          stall,
    output logic [AW-1:0] pm_addr,
    output logic          pm_en,
    input  logic [15:0]   pm_data,
    output logic [2:0]    operandIndex1,
    output logic [2:0]    operandIndex2,
    output logic [2:0]    resultsIndex,
    output logic [5:0]    operation,
    output logic [3:0]    params,
    output logic          immediate,
    output logic          readBus,
    output logic [15:0]   bus_data,
    output logic          busy,
    output logic          halted
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StExec,
        StFetchImm,
        StWaitImm,
        StWriteImm,
        StHalted
    } state_e;

    localparam logic [2:0] ClsNop    = 3'd0;
    localparam logic [2:0] ClsAddSub = 3'd1;
    localparam logic [2:0] ClsMul    = 3'd2;
    localparam logic [2:0] ClsLogic  = 3'd3;
    localparam logic [2:0] ClsLsh    = 3'd4;
    localparam logic [2:0] ClsRsh    = 3'd5;
    localparam logic [2:0] ClsLdi    = 3'd6;
    localparam logic [2:0] ClsHalt   = 3'd7;

    localparam logic [AW-1:0] StartPc = AW'(START);
    localparam logic [AW-1:0] PcOne   = AW'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   ir_q, ir_d;
    logic [15:0]   bus_data_q, bus_data_d;
    logic          captured_q, captured_d;

    logic [2:0]    cls;
    logic [5:0]    exec_op;
    logic          exec_imm;

    assign cls = ir_q[15:13];

    always_comb begin
        exec_op  = 6'b000000;
        exec_imm = 1'b0;
        case (cls)
            ClsAddSub: begin exec_op = 6'b100001; exec_imm = 1'b1; end
            ClsMul:    begin exec_op = 6'b100010; exec_imm = 1'b1; end
            ClsLogic:  begin exec_op = 6'b100100; exec_imm = 1'b1; end
            ClsLsh:    exec_op = 6'b101000;
            ClsRsh:    exec_op = 6'b110000;
            ClsNop, ClsLdi, ClsHalt: exec_op = 6'b000000;
            default:   exec_op = 6'b000000;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        bus_data_d = bus_data_q;
        captured_d = captured_q;
        operation  = 6'b000000;
        readBus    = 1'b0;
        immediate  = 1'b0;
        pm_en      = 1'b0;

        case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StFetch;
                    pc_d    = StartPc;
                end
            end
            StFetch: begin
                if (!stall) begin
                    pm_en   = 1'b1;
                    state_d = StWait;
                end
            end
            StWait: begin
                // ROM output is not held, so capture on the first WAIT cycle even when stalled
                if (!captured_q) begin
                    ir_d       = pm_data;
                    captured_d = 1'b1;
                end
                if (!stall) begin
                    state_d    = StExec;
                    captured_d = 1'b0;
                end
            end
            StExec: begin
                immediate = exec_imm;
                if (!stall) begin
                    operation = exec_op;
                    pc_d      = pc_q + PcOne;
                    if (cls == ClsLdi) begin
                        state_d = StFetchImm;
                    end else if (cls == ClsHalt) begin
                        state_d = StHalted;
                    end else begin
                        state_d = run ? StFetch : StIdle;
                    end
                end
            end
            StFetchImm: begin
                if (!stall) begin
                    pm_en   = 1'b1;
                    state_d = StWaitImm;
                end
            end
            StWaitImm: begin
                if (!captured_q) begin
                    bus_data_d = pm_data;
                    captured_d = 1'b1;
                end
                if (!stall) begin
                    state_d    = StWriteImm;
                    captured_d = 1'b0;
                end
            end
            StWriteImm: begin
                if (!stall) begin
                    operation = 6'b100000;
                    readBus   = 1'b1;
                    pc_d      = pc_q + PcOne;
                    state_d   = run ? StFetch : StIdle;
                end
            end
            StHalted: begin
                if (!run) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            pc_q       <= StartPc;
            ir_q       <= 16'h0000;
            bus_data_q <= 16'h0000;
            captured_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            bus_data_q <= bus_data_d;
            captured_q <= captured_d;
        end
    end

    assign pm_addr       = pc_q;
    assign resultsIndex  = ir_q[12:10];
    assign operandIndex1 = ir_q[9:7];
    assign operandIndex2 = ir_q[6:4];
    assign params        = ir_q[3:0];
    assign bus_data      = bus_data_q;
    assign busy          = (state_q != StIdle) && (state_q != StHalted);
    assign halted        = (state_q == StHalted);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: table of single-word instructions plus hand-written
// sequences for LDI, HALT, stalls, run drop, pc wrap and mid-instruction reset.
module tb_alu_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: AW=8, START=0
    logic        rst0, run0, stall0, pm_en0, imm0, rb0, busy0, halt0;
    logic [7:0]  pm_addr0;
    logic [15:0] pm_data0, bus0;
    logic [2:0]  rs1_0, rs2_0, rd0;
    logic [5:0]  op0;
    logic [3:0]  prm0;

    // Instance 1: AW=4, START=15 for the wrap-around case
    logic        rst1, run1, stall1, pm_en1, imm1, rb1, busy1, halt1;
    logic [3:0]  pm_addr1;
    logic [15:0] pm_data1, bus1;
    logic [2:0]  rs1_1, rs2_1, rd1;
    logic [5:0]  op1;
    logic [3:0]  prm1;

    alu_sequencer #(.AW(8), .START(0)) dut0 (
        .CLK(clk), .RST(rst0), .run(run0), .stall(stall0),
        .pm_addr(pm_addr0), .pm_en(pm_en0), .pm_data(pm_data0),
        .operandIndex1(rs1_0), .operandIndex2(rs2_0), .resultsIndex(rd0),
        .operation(op0), .params(prm0), .immediate(imm0), .readBus(rb0),
        .bus_data(bus0), .busy(busy0), .halted(halt0)
    );

    alu_sequencer #(.AW(4), .START(15)) dut1 (
        .CLK(clk), .RST(rst1), .run(run1), .stall(stall1),
        .pm_addr(pm_addr1), .pm_en(pm_en1), .pm_data(pm_data1),
        .operandIndex1(rs1_1), .operandIndex2(rs2_1), .resultsIndex(rd1),
        .operation(op1), .params(prm1), .immediate(imm1), .readBus(rb1),
        .bus_data(bus1), .busy(busy1), .halted(halt1)
    );

    // ROM models: the output is not held when not strobed, it shows a junk word instead
    logic [15:0] rom0 [256];
    logic [15:0] rom1 [16];
    always @(posedge clk) pm_data0 <= pm_en0 ? rom0[pm_addr0] : 16'hDEAD;
    always @(posedge clk) pm_data1 <= pm_en1 ? rom1[pm_addr1] : 16'hDEAD;

    int ops0 = 0;
    always @(posedge clk) if (op0 != 6'd0) ops0 <= ops0 + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] instr;
        logic [5:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [3:0]  prm;
        logic        imm;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic reset0();
        rst0   = 1'b1;
        run0   = 1'b0;
        stall0 = 1'b0;
        for (int i = 0; i < 256; i++) rom0[i] = 16'h0000;
        tick();
        rst0 = 1'b0;
        tick();
    endtask

    initial begin
        int base;
        rst0 = 1'b1; run0 = 1'b0; stall0 = 1'b0;
        rst1 = 1'b1; run1 = 1'b0; stall1 = 1'b0;
        for (int i = 0; i < 256; i++) rom0[i] = 16'h0000;
        for (int i = 0; i < 16; i++) rom1[i] = 16'h0000;

        vecs[0] = '{16'h2A30, 6'b100001, 3'd2, 3'd4, 3'd3, 4'h0, 1'b1}; // ADDSUB
        vecs[1] = '{16'h5CE5, 6'b100010, 3'd7, 3'd1, 3'd6, 4'h5, 1'b1}; // MUL
        vecs[2] = '{16'h6EAA, 6'b100100, 3'd3, 3'd5, 3'd2, 4'hA, 1'b1}; // LOGIC
        vecs[3] = '{16'h8383, 6'b101000, 3'd0, 3'd7, 3'd0, 4'h3, 1'b0}; // LSH
        vecs[4] = '{16'hA08F, 6'b110000, 3'd0, 3'd1, 3'd0, 4'hF, 1'b0}; // RSH
        vecs[5] = '{16'h1FFF, 6'b000000, 3'd7, 3'd7, 3'd7, 4'hF, 1'b0}; // NOP

        #1;
        chk("rst_op",     32'(op0),    32'h0);
        chk("rst_readbus", 32'(rb0),   32'h0);
        chk("rst_imm",    32'(imm0),   32'h0);
        chk("rst_pm_en",  32'(pm_en0), 32'h0);
        chk("rst_bus",    32'(bus0),   32'h0);
        chk("rst_halted", 32'(halt0),  32'h0);
        chk("rst_busy",   32'(busy0),  32'h0);

        // Single-word instructions: EXEC is the third cycle after run
        for (int v = 0; v < 6; v++) begin
            reset0();
            rom0[0] = vecs[v].instr;
            run0 = 1'b1;
            tick(); tick(); tick();
            chk($sformatf("v%0d_op", v),   32'(op0),   32'(vecs[v].op));
            chk($sformatf("v%0d_rd", v),   32'(rd0),   32'(vecs[v].rd));
            chk($sformatf("v%0d_rs1", v),  32'(rs1_0), 32'(vecs[v].rs1));
            chk($sformatf("v%0d_rs2", v),  32'(rs2_0), 32'(vecs[v].rs2));
            chk($sformatf("v%0d_prm", v),  32'(prm0),  32'(vecs[v].prm));
            chk($sformatf("v%0d_imm", v),  32'(imm0),  32'(vecs[v].imm));
            chk($sformatf("v%0d_busy", v), 32'(busy0), 32'h1);
            tick();
            chk($sformatf("v%0d_op_after", v), 32'(op0),     32'h0);
            chk($sformatf("v%0d_next_pm", v),  32'(pm_addr0), 32'h1);
            chk($sformatf("v%0d_next_en", v),  32'(pm_en0),   32'h1);
        end

        // LDI r1, 0xBEEF
        reset0();
        rom0[0] = 16'hC400;
        rom0[1] = 16'hBEEF;
        run0 = 1'b1;
        tick(); tick(); tick();
        chk("ldi_exec_op", 32'(op0), 32'h0);
        chk("ldi_exec_rb", 32'(rb0), 32'h0);
        tick();
        chk("ldi_fimm_addr", 32'(pm_addr0), 32'h1);
        chk("ldi_fimm_en",   32'(pm_en0),   32'h1);
        tick(); tick();
        chk("ldi_wr_rb",  32'(rb0),  32'h1);
        chk("ldi_wr_bus", 32'(bus0), 32'hBEEF);
        chk("ldi_wr_op",  32'(op0),  32'h20);
        chk("ldi_wr_rd",  32'(rd0),  32'h1);
        tick();
        chk("ldi_next_addr", 32'(pm_addr0), 32'h2);
        chk("ldi_next_en",   32'(pm_en0),   32'h1);
        chk("ldi_next_rb",   32'(rb0),      32'h0);
        chk("ldi_bus_hold",  32'(bus0),     32'hBEEF);

        // HALT, then run 1->0->1 restarts at START
        reset0();
        rom0[0] = 16'hE000;
        run0 = 1'b1;
        tick(); tick(); tick();
        chk("halt_exec_op", 32'(op0), 32'h0);
        tick();
        chk("halt_halted", 32'(halt0), 32'h1);
        chk("halt_busy",   32'(busy0), 32'h0);
        tick(); tick(); tick();
        chk("halt_stays",  32'(halt0),    32'h1);
        chk("halt_op",     32'(op0),      32'h0);
        chk("halt_pc",     32'(pm_addr0), 32'h1);
        run0 = 1'b0;
        tick();
        chk("halt_to_idle", 32'(halt0), 32'h0);
        chk("idle_busy",    32'(busy0), 32'h0);
        run0 = 1'b1;
        tick();
        chk("restart_en",   32'(pm_en0),   32'h1);
        chk("restart_addr", 32'(pm_addr0), 32'h0);

        // Stall for 4 cycles starting in EXEC of RSH
        reset0();
        rom0[0] = 16'hA08F;
        run0 = 1'b1;
        tick(); tick(); tick();
        base = ops0;
        for (int i = 0; i < 4; i++) begin
            stall0 = 1'b1;
            #1;
            chk($sformatf("stx_op_%0d", i),   32'(op0),   32'h0);
            chk($sformatf("stx_busy_%0d", i), 32'(busy0), 32'h1);
            tick();
        end
        stall0 = 1'b0;
        #1;
        chk("stx_op_rel",  32'(op0),  32'h30);
        chk("stx_prm_rel", 32'(prm0), 32'hF);
        tick();
        chk("stx_op_after", 32'(op0),      32'h0);
        chk("stx_once",     32'(ops0 - base), 32'h1);
        chk("stx_pc",       32'(pm_addr0), 32'h1);

        // Stall in WAIT: the ROM word must be captured once and not overwritten
        reset0();
        rom0[0] = 16'h2A30;
        run0 = 1'b1;
        tick(); tick();
        stall0 = 1'b1;
        tick(); tick();
        stall0 = 1'b0;
        tick();
        chk("stw_op",  32'(op0),   32'h21);
        chk("stw_rd",  32'(rd0),   32'h2);
        chk("stw_rs1", 32'(rs1_0), 32'h4);

        // Stall in FETCH: strobe suppressed until released
        reset0();
        rom0[0] = 16'h5CE5;
        run0 = 1'b1;
        tick();
        stall0 = 1'b1;
        #1;
        chk("stf_en", 32'(pm_en0), 32'h0);
        tick();
        stall0 = 1'b0;
        #1;
        chk("stf_en_rel", 32'(pm_en0), 32'h1);
        tick(); tick();
        chk("stf_op", 32'(op0), 32'h22);

        // run drops while busy: instruction completes, then IDLE with pc kept
        reset0();
        rom0[0] = 16'h2A30;
        rom0[1] = 16'h5CE5;
        run0 = 1'b1;
        tick();
        run0 = 1'b0;
        tick(); tick();
        chk("drop_exec_op", 32'(op0), 32'h21);
        tick();
        chk("drop_busy",  32'(busy0),  32'h0);
        chk("drop_pm_en", 32'(pm_en0), 32'h0);
        tick();
        chk("drop_idle", 32'(busy0),    32'h0);
        chk("drop_pc",   32'(pm_addr0), 32'h1);
        run0 = 1'b1;
        tick();
        chk("drop_restart_en",   32'(pm_en0),   32'h1);
        chk("drop_restart_addr", 32'(pm_addr0), 32'h0);

        // AW=4: LDI at 15 wraps its operand fetch to 0, then reset in WAIT_IMM
        rom1[15] = 16'hC400;
        rom1[0]  = 16'h1234;
        rom1[1]  = 16'hC800;
        rom1[2]  = 16'h5678;
        tick();
        rst1 = 1'b0;
        tick();
        run1 = 1'b1;
        tick();
        chk("wrap_fetch_addr", 32'(pm_addr1), 32'hF);
        tick(); tick(); tick();
        chk("wrap_imm_addr", 32'(pm_addr1), 32'h0);
        chk("wrap_imm_en",   32'(pm_en1),   32'h1);
        tick(); tick();
        chk("wrap_wr_bus", 32'(bus1), 32'h1234);
        chk("wrap_wr_rb",  32'(rb1),  32'h1);
        chk("wrap_wr_op",  32'(op1),  32'h20);
        chk("wrap_wr_rd",  32'(rd1),  32'h1);
        tick();
        chk("wrap_next_addr", 32'(pm_addr1), 32'h1);
        tick(); tick(); tick();
        chk("wrap2_imm_addr", 32'(pm_addr1), 32'h2);
        tick();
        rst1 = 1'b1;
        #1;
        chk("mid_rst_op",   32'(op1),      32'h0);
        chk("mid_rst_rb",   32'(rb1),      32'h0);
        chk("mid_rst_en",   32'(pm_en1),   32'h0);
        chk("mid_rst_bus",  32'(bus1),     32'h0);
        chk("mid_rst_busy", 32'(busy1),    32'h0);
        chk("mid_rst_halt", 32'(halt1),    32'h0);
        chk("mid_rst_imm",  32'(imm1),     32'h0);
        chk("mid_rst_pc",   32'(pm_addr1), 32'hF);
        tick();
        rst1 = 1'b0;
        run1 = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Fetch/decode stage directly upstream of the 8-register ALU.
- Reads 16-bit instruction words from a synchronous program ROM and decodes them.
- For exactly one cycle per instruction, drives the ALU control bundle: register indices, one-hot operation, params, immediate and readBus.
- Supplies the ALU's din for two-word load-immediate (LDI) instructions.

Parameters:
- AW, 8, program address width; pc wraps modulo 2^AW.
- START, 0, pc value loaded on reset and on each run start from IDLE.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  asynchronous, active-high reset.
- run  in  1  level; starts execution from IDLE.
- stall  in  1  freezes the sequencer for the cycle.
- pm_addr  out  AW  ROM address.
- pm_en  out  1  ROM read strobe.
- pm_data  in  16  ROM data, valid the cycle after pm_en.
- operandIndex1  out  3  ALU first-operand register index (rs1).
- operandIndex2  out  3  ALU second-operand register index (rs2).
- resultsIndex  out  3  ALU destination register index (rd).
- operation  out  6  one-hot ALU operation; bit5 = write enable.
- params  out  4  ALU sub-op / shift amount.
- immediate  out  1  high = second operand comes from a register.
- readBus  out  1  ALU loads its destination from din.
- bus_data  out  16  drives the ALU's din.
- busy  out  1  high in every state except IDLE and HALTED.
- halted  out  1  high in HALTED.

Behaviour:
- Instruction word fields:
  - [15:13] class: 0 NOP, 1 ADDSUB, 2 MUL, 3 LOGIC, 4 LSH, 5 RSH, 6 LDI, 7 HALT.
  - [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] params.
- States: IDLE, FETCH, WAIT, EXEC, FETCH_IMM, WAIT_IMM, WRITE_IMM, HALTED.
- Reset (async, any state, including mid-instruction):
  - state=IDLE, pc=START, ir=0.
  - All outputs 0: operation=0, readBus=0, immediate=0, pm_en=0, bus_data=0, halted=0, busy=0.
- IDLE: run=1 -> FETCH.
- FETCH: pm_en=1, pm_addr=pc -> WAIT.
- WAIT: ir<=pm_data -> EXEC.
- EXEC (one cycle):
  - Outputs are combinational from ir: resultsIndex=rd, operandIndex1=rs1, operandIndex2=rs2, params=ir[3:0].
  - operation by class:
    - ADDSUB: 6'b100001
    - MUL: 6'b100010
    - LOGIC: 6'b100100
    - LSH: 6'b101000
    - RSH: 6'b110000
    - NOP, LDI, HALT: 0
  - immediate=1 for ADDSUB, MUL, LOGIC; 0 otherwise.
  - pc<=pc+1 (mod 2^AW).
  - Next state: LDI -> FETCH_IMM; HALT -> HALTED; all others -> FETCH.
- FETCH_IMM: pm_en=1, pm_addr=pc -> WAIT_IMM.
- WAIT_IMM: bus_data<=pm_data -> WRITE_IMM.
- WRITE_IMM: operation=6'b100000, readBus=1, resultsIndex=rd, pc<=pc+1 -> FETCH.
- HALTED:
  - halted=1, pc frozen at the address after HALT.
  - Leaves only via RST, or run=0 followed by run=1: run falling -> IDLE, then restart from START.
- Outside EXEC and WRITE_IMM: operation=0, readBus=0.
- bus_data holds its last value until the next WAIT_IMM.
- Latency: 3 cycles per ordinary instruction, 6 per LDI. ALU result is visible in its register file the cycle after EXEC/WRITE_IMM.
- stall=1:
  - No state, pc or ir change; operation, readBus and pm_en forced 0.
  - Stall in WAIT: the ROM word is still captured, because the ROM output is not held. Rule: ir/bus_data load in WAIT/WAIT_IMM regardless of stall, while state is held; re-entering WAIT after the stall must not reload. An internal captured flag is required for this.
  - Stall in EXEC or WRITE_IMM: the write strobe is deferred to the first unstalled cycle; it is issued exactly once.
- run dropping while busy: the current instruction completes, then the sequencer goes to IDLE instead of FETCH. pc is retained; restart reloads START.
- Wrap-around: instruction at 2^AW-1 fetches its next word, or its LDI operand, from address 0.

Test Plan:
- Reset, run=1, ROM[0]=0x2A30 (ADDSUB rd=2 rs1=4 rs2=3 p=0) -> cycle 3 after run: operation=6'b100001, resultsIndex=2, operandIndex1=4, operandIndex2=3, immediate=1, one cycle only.
- ROM[0]=0xC400 (LDI rd=1), ROM[1]=0xBEEF -> WRITE_IMM cycle: readBus=1, bus_data=0xBEEF, operation=6'b100000, resultsIndex=1; next fetch at pm_addr=2.
- ROM[0]=0xE000 (HALT) -> halted=1, busy=0, operation stays 0; run 1->0->1 -> fetch restarts at pm_addr=START.
- stall=1 for 4 cycles starting in EXEC of an RSH (0xA08F) -> operation=6'b110000 asserted once, on the first cycle after stall falls, params=0xF.
- AW=4, LDI at address 15 -> operand fetched from pm_addr=0, next instruction fetched from address 1; RST asserted in WAIT_IMM -> all outputs 0 immediately, pc=START.
